// File: rtl/regfile_pkg.sv
// Shared types and constants for the RV32E register file write path.
// Provides register-address legality for the 5-bit rd/rs fields.
package regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int RD_W       = 5;
  localparam int BIT_WIDTH  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [RD_W-1:0]       rd_field_t;
  typedef logic [BIT_WIDTH-1:0]  word_t;

  // RV32E has only x0..x15; bit 4 of the field must be clear
  function automatic logic rd_legal(rd_field_t rd);
    return !rd[RD_W-1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr and wraps modulo N; first active request wins.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic found;
    int   i;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = int'(ptr) + k;
      if (i >= N) i = i - N;
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the RV32E regfile write port with a
// pending-write scoreboard for read-after-write hazard detection.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int BIT_WIDTH = 32,
  parameter int NUM_REGS  = 16,
  parameter int RD_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*RD_W-1:0]      req_addr,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic                         rf_we,
  output logic [3:0]                   rf_waddr,
  output logic [BIT_WIDTH-1:0]         rf_wdata,
  input  logic                         claim_valid,
  input  logic [RD_W-1:0]              claim_addr,
  input  logic [RD_W-1:0]              rs_a,
  input  logic [RD_W-1:0]              rs_b,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         err_illegal
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_ptr_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 hs;
  rd_field_t            gaddr;
  logic [BIT_WIDTH-1:0] gdata;
  logic                 wr_ok;
  logic                 wr_err;
  logic                 claim_ok;
  logic                 claim_err;
  logic [NUM_REGS-1:0]  busy_nxt;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign gaddr     = req_addr[int'(grant_idx)*RD_W +: RD_W];
  assign gdata     = req_data[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];

  // x0 and out-of-range writes are accepted but never reach the regfile
  assign wr_ok  = hs && rd_legal(gaddr) && (gaddr != '0);
  assign wr_err = hs && !rd_legal(gaddr);

  assign claim_ok  = claim_valid && rd_legal(claim_addr)
                  && (claim_addr != '0);
  assign claim_err = claim_valid && (!rd_legal(claim_addr)
                  || (claim_ok && busy[claim_addr[3:0]]));

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (hs) begin
      if (int'(grant_idx) == NUM_REQ - 1) rr_ptr_nxt = '0;
      else rr_ptr_nxt = grant_idx + 1'b1;
    end
  end

  // Clear first so a same-cycle claim of the same register wins
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_waddr] = 1'b0;
    if (claim_ok) busy_nxt[claim_addr[3:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      busy        <= '0;
      err_illegal <= 1'b0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      rf_we       <= wr_ok;
      busy        <= busy_nxt;
      err_illegal <= wr_err | claim_err;
      if (wr_ok) begin
        rf_waddr <= gaddr[3:0];
        rf_wdata <= gdata;
      end
    end
  end

  assign hazard_a = busy[rs_a[3:0]] && (rs_a != '0) && !rs_a[4];
  assign hazard_b = busy[rs_b[3:0]] && (rs_b != '0) && !rs_b[4];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Expected writes are queued at grant time and popped on rf_we.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int BW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*RW-1:0] req_addr;
  logic [NR*BW-1:0] req_data;
  logic           rf_we;
  logic [3:0]     rf_waddr;
  logic [BW-1:0]  rf_wdata;
  logic           claim_valid;
  logic [RW-1:0]  claim_addr;
  logic [RW-1:0]  rs_a;
  logic [RW-1:0]  rs_b;
  logic           hazard_a;
  logic           hazard_b;
  logic [15:0]    busy;
  logic           err_illegal;

  int  n_tests;
  int  n_fail;
  int  n_wr;
  wr_t q[$];

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .busy        (busy),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [4:0] a, logic [31:0] d);
    req_addr[i*RW +: RW] = a;
    req_data[i*BW +: BW] = d;
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      wr_t e;
      n_wr++;
      chk("wr_expected", q.size(), (q.size() > 0) ? q.size() : 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_addr", {28'd0, rf_waddr}, {28'd0, e.a});
        chk("wr_data", rf_wdata, e.d);
      end
    end
  end

  initial begin
    logic [4:0]  ca[3];
    logic [31:0] cd[3];
    n_tests = 0;
    n_fail = 0;
    n_wr = 0;
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    claim_valid = 1'b0;
    claim_addr = '0;
    rs_a = '0;
    rs_b = '0;

    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_wdata", rf_wdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // Contention: all three requesters hold valid for six grants
    ca[0] = 5'd1; ca[1] = 5'd2; ca[2] = 5'd3;
    cd[0] = 32'hA000_0001;
    cd[1] = 32'hB000_0002;
    cd[2] = 32'hC000_0003;
    for (int i = 0; i < 3; i++) set_req(i, ca[i], cd[i]);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_grant", {29'd0, req_ready},
          {29'd0, 3'(1 << (k % 3))});
      q.push_back('{a: ca[k%3][3:0], d: cd[k%3]});
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("cont_idle_we", rf_we, 0);
    chk("cont_nwr", n_wr, 6);

    // x0 write: granted and dropped silently
    tick();
    set_req(0, 5'd0, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    @(negedge clk);
    chk("x0_grant", {29'd0, req_ready}, 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("x0_we", rf_we, 0);
    chk("x0_err", err_illegal, 0);

    // Illegal rd (bit 4 set): dropped with a one-cycle error
    tick();
    set_req(1, 5'h13, 32'h1234_5678);
    req_valid = 3'b010;
    @(negedge clk);
    chk("ill_grant", {29'd0, req_ready}, 32'd2);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("ill_err", err_illegal, 1);
    chk("ill_we", rf_we, 0);
    @(negedge clk);
    chk("ill_err_off", err_illegal, 0);

    // Scoreboard round trip on x5
    tick();
    claim_valid = 1'b1;
    claim_addr = 5'd5;
    tick();
    claim_valid = 1'b0;
    rs_a = 5'd5;
    rs_b = 5'h15;
    @(negedge clk);
    chk("sb_busy5", busy[5], 1);
    chk("sb_haz_a", hazard_a, 1);
    chk("sb_haz_b_ill", hazard_b, 0);
    chk("sb_claim_err", err_illegal, 0);
    rs_b = 5'd0;
    #1;
    chk("sb_haz_b_x0", hazard_b, 0);
    tick();
    set_req(1, 5'd5, 32'h5555_0005);
    req_valid = 3'b010;
    @(negedge clk);
    chk("sb_grant", {29'd0, req_ready}, 32'd2);
    q.push_back('{a: 4'd5, d: 32'h5555_0005});
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("sb_we", rf_we, 1);
    chk("sb_haz_we", hazard_a, 1);
    @(negedge clk);
    chk("sb_busy5_clr", busy[5], 0);
    chk("sb_haz_clr", hazard_a, 0);

    // Same-cycle set and clear of x7: set wins
    tick();
    set_req(2, 5'd7, 32'h7777_0007);
    req_valid = 3'b100;
    @(negedge clk);
    chk("col_grant", {29'd0, req_ready}, 32'd4);
    q.push_back('{a: 4'd7, d: 32'h7777_0007});
    tick();
    req_valid = '0;
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    @(negedge clk);
    chk("col_we", rf_we, 1);
    tick();
    claim_valid = 1'b0;
    @(negedge clk);
    chk("col_busy7", busy[7], 1);
    chk("col_err", err_illegal, 0);
    tick();
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    tick();
    claim_valid = 1'b0;
    @(negedge clk);
    chk("dup_err", err_illegal, 1);
    @(negedge clk);
    chk("dup_err_off", err_illegal, 0);
    chk("dup_busy7", busy[7], 1);

    // Fairness after idle: pointer at 0 after req2, so req1 wins
    repeat (3) tick();
    set_req(1, 5'd9, 32'h9999_0009);
    set_req(2, 5'd10, 32'hAAAA_000A);
    req_valid = 3'b110;
    @(negedge clk);
    chk("fair_grant", {29'd0, req_ready}, 32'd2);
    q.push_back('{a: 4'd9, d: 32'h9999_0009});
    tick();
    req_valid = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while a write is pending
    tick();
    set_req(0, 5'd11, 32'hBBBB_000B);
    req_valid = 3'b001;
    @(negedge clk);
    chk("rstw_grant", {29'd0, req_ready}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("rstw_we", rf_we, 0);
    chk("rstw_waddr", {28'd0, rf_waddr}, 0);
    chk("rstw_wdata", rf_wdata, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_err", err_illegal, 0);
    tick();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_no_wr", rf_we, 0);
    end

    chk("q_empty", q.size(), 0);
    chk("total_wr", n_wr, 9);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
